// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path: opcodes, FSM states
// and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode -> immediate-format select; purely combinational so the single-cycle
// core can reuse it unchanged.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath over a unified memory with a
// ready handshake; Moore outputs except the mem_ready/zero-qualified enables.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t state, next_state;
    logic   illegal_q;

    imm_src_decoder u_imm_dec (.op(op), .imm_src(imm_src));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
                next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_SUB;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            S_ILLEGAL: next_state = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:   next_state = S_FETCH;
        endcase
        // FETCH drives live enables, so reset must mask them combinationally.
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            result_src = 2'b00;
            instr_done = 1'b0;
        end
    end

    assign illegal   = illegal_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed checks of the multicycle controller: per-cycle state plus every
// control output compared against hand-built tables.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic       instr_done, illegal;
    logic [3:0] state_dbg;

    logic       mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0;
    logic [1:0] alu_src_a0, alu_src_b0, alu_op0, result_src0, imm_src0;
    logic       instr_done0, illegal0;
    logic [3:0] state_dbg0;

    int checks = 0;
    int passed = 0;

    logic [21:0] exp_tab [0:15];
    logic        rdy_tab [0:15];

    // {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    //  a, b, alu_op, result_src, imm_src, instr_done, illegal}
    logic [21:0] obs, obs0;
    assign obs  = {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, alu_op, result_src, imm_src, instr_done, illegal};
    assign obs0 = {state_dbg0, mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0,
                   alu_src_a0, alu_src_b0, alu_op0, result_src0, imm_src0, instr_done0, illegal0};

    always #5 clk = ~clk;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .instr_done(instr_done),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req0), .mem_write(mem_write0), .adr_src(adr_src0),
        .ir_write(ir_write0), .pc_write(pc_write0), .reg_write(reg_write0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
        .result_src(result_src0), .imm_src(imm_src0), .instr_done(instr_done0),
        .illegal(illegal0), .state_dbg(state_dbg0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; op = 7'b0; zero = 1'b0; mem_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (obs !== 22'b0) $display("FAIL reset obs=%b exp=%b", obs, 22'b0);
        else passed++;
        checks++;
        if (obs0 !== 22'b0) $display("FAIL reset_h0 obs=%b exp=%b", obs0, 22'b0);
        else passed++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_lw();
        op = 7'b0000011; zero = 1'b0;
        exp_tab[0] = {4'd0, 18'b100110_00_10_00_10_00_00}; rdy_tab[0] = 1'b1;
        exp_tab[1] = {4'd1, 18'b000000_01_01_00_00_00_00}; rdy_tab[1] = 1'b1;
        exp_tab[2] = {4'd2, 18'b000000_10_01_00_00_00_00}; rdy_tab[2] = 1'b1;
        exp_tab[3] = {4'd3, 18'b101000_00_00_00_00_00_00}; rdy_tab[3] = 1'b1;
        exp_tab[4] = {4'd4, 18'b000001_00_00_00_01_00_10}; rdy_tab[4] = 1'b1;
        exp_tab[5] = {4'd0, 18'b100110_00_10_00_10_00_00}; rdy_tab[5] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mem_ready = rdy_tab[c]; #1;
            checks++;
            if (obs !== exp_tab[c]) $display("FAIL lw cyc%0d obs=%b exp=%b", c, obs, exp_tab[c]);
            else passed++;
            if (c != 5) tick();
        end
    endtask

    task automatic test_sw_wait();
        op = 7'b0100011;
        exp_tab[0] = {4'd0, 18'b100110_00_10_00_10_01_00}; rdy_tab[0] = 1'b1;
        exp_tab[1] = {4'd1, 18'b000000_01_01_00_00_01_00}; rdy_tab[1] = 1'b0;
        exp_tab[2] = {4'd2, 18'b000000_10_01_00_00_01_00}; rdy_tab[2] = 1'b0;
        exp_tab[3] = {4'd5, 18'b111000_00_00_00_00_01_00}; rdy_tab[3] = 1'b0;
        exp_tab[4] = {4'd5, 18'b111000_00_00_00_00_01_00}; rdy_tab[4] = 1'b0;
        exp_tab[5] = {4'd5, 18'b111000_00_00_00_00_01_00}; rdy_tab[5] = 1'b0;
        exp_tab[6] = {4'd5, 18'b111000_00_00_00_00_01_10}; rdy_tab[6] = 1'b1;
        exp_tab[7] = {4'd0, 18'b100110_00_10_00_10_01_00}; rdy_tab[7] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mem_ready = rdy_tab[c]; #1;
            checks++;
            if (obs !== exp_tab[c]) $display("FAIL sw cyc%0d obs=%b exp=%b", c, obs, exp_tab[c]);
            else passed++;
            if (c != 7) tick();
        end
    endtask

    task automatic test_alu();
        // R-type with one FETCH stall, then I-type back to back
        op = 7'b0110011;
        exp_tab[0] = {4'd0, 18'b100000_00_10_00_10_00_00}; rdy_tab[0] = 1'b0;
        exp_tab[1] = {4'd0, 18'b100110_00_10_00_10_00_00}; rdy_tab[1] = 1'b1;
        exp_tab[2] = {4'd1, 18'b000000_01_01_00_00_00_00}; rdy_tab[2] = 1'b1;
        exp_tab[3] = {4'd6, 18'b000000_10_00_10_00_00_00}; rdy_tab[3] = 1'b1;
        exp_tab[4] = {4'd8, 18'b000001_00_00_00_00_00_10}; rdy_tab[4] = 1'b1;
        exp_tab[5] = {4'd0, 18'b100110_00_10_00_10_00_00}; rdy_tab[5] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mem_ready = rdy_tab[c]; #1;
            checks++;
            if (obs !== exp_tab[c]) $display("FAIL rtype cyc%0d obs=%b exp=%b", c, obs, exp_tab[c]);
            else passed++;
            if (c != 5) tick();
        end
        op = 7'b0010011;
        exp_tab[0] = {4'd0, 18'b100110_00_10_00_10_00_00};
        exp_tab[1] = {4'd1, 18'b000000_01_01_00_00_00_00};
        exp_tab[2] = {4'd7, 18'b000000_10_01_10_00_00_00};
        exp_tab[3] = {4'd8, 18'b000001_00_00_00_00_00_10};
        exp_tab[4] = {4'd0, 18'b100110_00_10_00_10_00_00};
        mem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (obs !== exp_tab[c]) $display("FAIL itype cyc%0d obs=%b exp=%b", c, obs, exp_tab[c]);
            else passed++;
            if (c != 4) tick();
        end
    endtask

    task automatic test_beq();
        op = 7'b1100011; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            exp_tab[0] = {4'd0, 18'b100110_00_10_00_10_10_00};
            exp_tab[1] = {4'd1, 18'b000000_01_01_00_00_10_00};
            exp_tab[2] = {4'd9, 5'b00000, z[0], 12'b000000_10_00_01_00_10_10} >> 0;
            exp_tab[2] = {4'd9, 4'b0000, z[0], 1'b0, 12'b10_00_01_00_10_10};
            exp_tab[3] = {4'd0, 18'b100110_00_10_00_10_10_00};
            for (int c = 0; c < 4; c++) begin
                #1;
                checks++;
                if (obs !== exp_tab[c]) $display("FAIL beq_z%0d cyc%0d obs=%b exp=%b", z, c, obs, exp_tab[c]);
                else passed++;
                if (c != 3) tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111; mem_ready = 1'b1;
        exp_tab[0] = {4'd0,  18'b100110_00_10_00_10_11_00};
        exp_tab[1] = {4'd1,  18'b000000_01_01_00_00_11_00};
        exp_tab[2] = {4'd10, 18'b000010_01_10_00_00_11_00};
        exp_tab[3] = {4'd8,  18'b000001_00_00_00_00_11_10};
        exp_tab[4] = {4'd0,  18'b100110_00_10_00_10_11_00};
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (obs !== exp_tab[c]) $display("FAIL jal cyc%0d obs=%b exp=%b", c, obs, exp_tab[c]);
            else passed++;
            if (c != 4) tick();
        end
    endtask

    task automatic test_illegal();
        op = 7'b1110011; mem_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (obs0 !== {4'd11, 18'b000000_00_00_00_00_00_01})
            $display("FAIL illegal_h0_enter obs=%b exp=%b", obs0, {4'd11, 18'b000000_00_00_00_00_00_01});
        else passed++;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (obs !== {4'd11, 18'b000000_00_00_00_00_00_01})
                $display("FAIL illegal_halt cyc%0d obs=%b exp=%b", c, obs, {4'd11, 18'b000000_00_00_00_00_00_01});
            else passed++;
            if (c == 0) begin
                tick();
                #1;
                checks++;
                if (obs0 !== {4'd0, 18'b100110_00_10_00_10_00_01})
                    $display("FAIL illegal_h0_exit obs=%b exp=%b", obs0, {4'd0, 18'b100110_00_10_00_10_00_01});
                else passed++;
            end else begin
                tick();
                #1;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        // dut is parked in ILLEGAL with illegal=1; only reset gets it out
        rst = 1'b1; #1;
        checks++;
        if (obs !== 22'b0) $display("FAIL rst_from_illegal obs=%b exp=%b", obs, 22'b0);
        else passed++;
        tick();
        rst = 1'b0; op = 7'b0100011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0; #1;
        checks++;
        if (obs !== {4'd5, 18'b111000_00_00_00_00_01_00})
            $display("FAIL rst_pre_write obs=%b exp=%b", obs, {4'd5, 18'b111000_00_00_00_00_01_00});
        else passed++;
        rst = 1'b1; #1;
        checks++;
        if (obs !== {4'd0, 18'b000000_00_00_00_00_01_00})
            $display("FAIL rst_mid_write obs=%b exp=%b", obs, {4'd0, 18'b000000_00_00_00_00_01_00});
        else passed++;
        tick();
        checks++;
        if (obs !== {4'd0, 18'b000000_00_00_00_00_01_00})
            $display("FAIL rst_hold obs=%b exp=%b", obs, {4'd0, 18'b000000_00_00_00_00_01_00});
        else passed++;
        rst = 1'b0; mem_ready = 1'b1; #1;
        checks++;
        if (obs !== {4'd0, 18'b100110_00_10_00_10_01_00})
            $display("FAIL rst_release obs=%b exp=%b", obs, {4'd0, 18'b100110_00_10_00_10_01_00});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
